// File: rtl/rt_pkg.sv
// ----------------------------------------------------------------------------
// rt_pkg: shared state encoding and default timing constants. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rt_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_GO   = 2'd2,
    S_DONE = 2'd3
  } rt_state_t;

  localparam int RAND_W          = 5;
  localparam int TICK_DIV_DEF    = 50000;
  localparam int MIN_DELAY_DEF   = 500;
  localparam int DELAY_SHIFT_DEF = 6;
  localparam int RT_W_DEF        = 12;

  // Width that holds the largest delay without truncation.
  function automatic int delay_width(input int min_delay, input int shift);
    return $clog2(min_delay + (((1 << RAND_W) - 1) << shift) + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/reaction_timer_if.sv
// ----------------------------------------------------------------------------
// reaction_timer_if: game-side control/result bundle of the reaction timer. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface reaction_timer_if
  import rt_pkg::*;
#(
  parameter int RT_W = RT_W_DEF
) ();

  logic [RAND_W-1:0] rand_in;
  logic              rand_freeze;
  logic              start;
  logic              abort;
  logic              btn;
  logic              busy;
  logic              go;
  logic              done;
  logic              early;
  logic              timeout;
  logic [RT_W-1:0]   reaction;

  modport master (
    output rand_in, start, abort, btn,
    input  rand_freeze, busy, go, done, early, timeout, reaction
  );

  modport slave (
    input  rand_in, start, abort, btn,
    output rand_freeze, busy, go, done, early, timeout, reaction
  );

endinterface

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ----------------------------------------------------------------------------
// tick_prescaler: counts 0..TICK_DIV-1, pulses tick on the terminal count. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tick_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int               CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

`default_nettype wire

// File: rtl/reaction_timer.sv
// ----------------------------------------------------------------------------
// reaction_timer: random pre-GO delay, then reaction measurement in ticks. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module reaction_timer
  import rt_pkg::*;
#(
  parameter int TICK_DIV    = TICK_DIV_DEF,
  parameter int MIN_DELAY   = MIN_DELAY_DEF,
  parameter int DELAY_SHIFT = DELAY_SHIFT_DEF,
  parameter int RT_W        = RT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  reaction_timer_if.slave  bus
);

  localparam int              DLY_W   = delay_width(MIN_DELAY, DELAY_SHIFT);
  localparam logic [RT_W-1:0] RT_MAX  = '1;
  localparam logic [RT_W-1:0] RT_LAST = RT_MAX - 1'b1;

  rt_state_t        state;
  rt_state_t        state_nx;
  logic [DLY_W-1:0] delay;
  logic [RT_W-1:0]  reaction;
  logic             early;
  logic             timeout;
  logic             btn_q;
  logic             tick;
  logic             press;
  logic             accept;
  logic             busy;
  logic             go;
  logic             done;

  // Prescaler is held at zero between rounds so the first tick lands TICK_DIV
  // cycles after start.
  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == S_IDLE),
    .tick (tick)
  );

  assign press  = bus.btn & ~btn_q;
  assign accept = (state == S_IDLE) & bus.start & ~bus.abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    go       = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) state_nx = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (press) begin
          state_nx = S_DONE;
        end else if (tick && (delay <= DLY_W'(1))) begin
          state_nx = S_GO;
        end
      end
      S_GO: begin
        busy = 1'b1;
        go   = 1'b1;
        if (press || (tick && (reaction == RT_LAST))) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (bus.abort) state_nx = S_IDLE;
  end

  // Results only change on an accepted start or inside a round; abort freezes them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_q    <= 1'b0;
      delay    <= '0;
      reaction <= '0;
      early    <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      btn_q <= bus.btn;
      if (accept) begin
        delay    <= DLY_W'(MIN_DELAY) + (DLY_W'(bus.rand_in) << DELAY_SHIFT);
        reaction <= '0;
        early    <= 1'b0;
        timeout  <= 1'b0;
      end else if (!bus.abort) begin
        case (state)
          S_WAIT: begin
            if (press) begin
              early    <= 1'b1;
              reaction <= '0;
            end else if (tick) begin
              delay <= delay - 1'b1;
            end
          end
          S_GO: begin
            if (!press && tick && (reaction != RT_MAX)) begin
              reaction <= reaction + 1'b1;
              if (reaction == RT_LAST) timeout <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rand_freeze = (state != S_IDLE);
  assign bus.busy        = busy;
  assign bus.go          = go;
  assign bus.done        = done;
  assign bus.early       = early;
  assign bus.timeout     = timeout;
  assign bus.reaction    = reaction;

endmodule

`default_nettype wire

// File: tb/tb_reaction_timer.sv
// ----------------------------------------------------------------------------
// tb_reaction_timer: randomized rounds checked against an edge-arithmetic model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_reaction_timer;

  localparam int TD   = 4;
  localparam int MIND = 2;
  localparam int SH   = 1;
  localparam int RW   = 4;
  localparam int RMAX = (1 << RW) - 1;
  localparam int FAR  = 100000;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  reaction_timer_if #(.RT_W(RW)) bus ();

  reaction_timer #(
    .TICK_DIV    (TD),
    .MIN_DELAY   (MIND),
    .DELAY_SHIFT (SH),
    .RT_W        (RW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Results the model expects to be held between rounds.
  int m_react   = 0;
  bit m_early   = 1'b0;
  bit m_timeout = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] obs();
    return {22'd0, bus.busy, bus.go, bus.done, bus.rand_freeze,
            bus.early, bus.timeout, bus.reaction};
  endfunction

  function automatic logic [31:0] pack_exp(bit b, bit g, bit d, bit f, bit e, bit t, int r);
    logic [RW-1:0] rv;
    rv = RW'(r);
    return {22'd0, b, g, d, f, e, t, rv};
  endfunction

  function automatic logic [31:0] idle_exp();
    return pack_exp(0, 0, 0, 0, m_early, m_timeout, m_react);
  endfunction

  // Edges from the start edge to the edge that enters GO.
  function automatic int go_rel(int rnd);
    return (MIND + (rnd << SH)) * TD;
  endfunction

  // One round, indexed by edges relative to the start edge (r=0).
  // btn is high for r < hi_until and from press_rel through the end edge.
  task automatic run_round(input int rnd, input int hi_until, input int press_rel,
                           input int abort_rel, input int restart_rel);
    int g, e, react_end;
    bit early_r, to_r, ab, no_round;
    logic [31:0] want;
    g  = go_rel(rnd);
    ab = (abort_rel >= 0);
    no_round = ab && (abort_rel == 0);
    if (press_rel <= g) begin
      early_r = 1; to_r = 0; e = press_rel; react_end = 0;
    end else if (press_rel > g + RMAX * TD) begin
      early_r = 0; to_r = 1; e = g + RMAX * TD; react_end = RMAX;
    end else begin
      early_r = 0; to_r = 0; e = press_rel; react_end = (press_rel - g - 1) / TD;
    end
    if (ab) begin
      early_r = 0; to_r = 0; e = abort_rel; react_end = 0;
    end
    if (hi_until > 0) begin
      bus.btn = 1'b1;
      @(posedge clk); @(negedge clk);
      check_eq("pre_high_idle", obs(), idle_exp());
    end
    for (int r = 0; r <= e + 3; r++) begin
      bus.start   = (r == 0) || (r == restart_rel && r < e && !no_round);
      bus.abort   = ab && (r == abort_rel);
      bus.btn     = (r < hi_until) || (r >= press_rel && r <= e);
      bus.rand_in = (r == 0) ? 5'(rnd) : 5'($urandom);
      @(posedge clk); @(negedge clk);
      if (no_round)
        want = idle_exp();
      else if (r < e)
        want = pack_exp(1, r >= g, 0, 1, 0, 0, (r >= g) ? (r - g) / TD : 0);
      else if (r == e)
        want = pack_exp(0, 0, !ab, !ab, early_r, to_r, react_end);
      else
        want = pack_exp(0, 0, 0, 0, early_r, to_r, react_end);
      check_eq($sformatf("rnd%0d_p%0d_r%0d", rnd, press_rel, r), obs(), want);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.btn   = 1'b0;
    if (!no_round) begin
      m_early = early_r; m_timeout = to_r; m_react = react_end;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int rnd, g, hi, pr, ab, rs;
    bus.rand_in = '0;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.btn     = 1'b0;

    #12;
    check_eq("reset_state", obs(), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("post_reset_idle", obs(), idle_exp());

    // Press 10 cycles after GO rises.
    run_round(5, 0, go_rel(5) + 10, -1, -1);
    // Early press in WAIT.
    run_round(9, 0, 5, -1, -1);
    // No press: saturating count and timeout.
    run_round(2, 0, FAR, -1, -1);
    // btn held through start, released, pressed again in GO.
    run_round(3, 4, go_rel(3) + 7, -1, -1);
    // Start while busy is ignored.
    run_round(7, 0, go_rel(7) + 21, -1, 20);
    // Abort in WAIT, then start+abort together.
    run_round(6, 0, FAR, 10, -1);
    run_round(4, 0, FAR, 0, -1);
    // rand_in = 0 yields MIN_DELAY, press on the tick edge at GO entry counts as early.
    run_round(0, 0, go_rel(0), -1, -1);

    // Asynchronous reset mid-GO.
    bus.rand_in = '0;
    bus.start   = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check_eq("pre_rst_go", obs(), pack_exp(1, 1, 0, 1, 0, 0, (10 - go_rel(0)) / TD));
    #2 rst = 1'b0;
    #1 check_eq("rst_async_outs", obs(), 32'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    m_early = 0; m_timeout = 0; m_react = 0;
    @(negedge clk);
    check_eq("rst_release_idle", obs(), idle_exp());

    for (int i = 0; i < 30; i++) begin
      rnd = $urandom_range(0, 31);
      g   = go_rel(rnd);
      hi  = 0; ab = -1; rs = -1;
      case ($urandom_range(0, 5))
        0: pr = $urandom_range(1, g);
        1: pr = $urandom_range(g + 1, g + RMAX * TD);
        2: pr = FAR;
        3: begin
          hi = $urandom_range(1, g);
          pr = $urandom_range(hi + 1, g + RMAX * TD);
        end
        4: begin
          pr = FAR;
          ab = $urandom_range(1, g - 1);
        end
        default: begin
          pr = FAR;
          ab = 0;
        end
      endcase
      if ($urandom_range(0, 1) == 1) rs = $urandom_range(1, 6);
      run_round(rnd, hi, pr, ab, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
